// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- instruction fetch unit
//
// Owns the architectural PC. It issues one word fetch at a time to
// instruction memory and buffers the returned instruction for the decoder
// until the decoder consumes it. The PC unit supplies the next PC at
// retirement. A flush redirects the PC and cancels any fetch still in flight.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem_req_*      fetch request (valid/ready); imem_addr is the current pc
//   imem_rsp_*      fetch response (never stalled), err marks an access fault
//   inst*           registered instruction, its pc and fault flag to decoder
//   inst_ready      decoder consumes inst this cycle
//   next_pc         next PC from the PC unit, used only on the inst handshake
//   flush/flush_pc  redirect request and its target
// ---------------------------------------------------------------------------
module ifu_fetch #(
   parameter int                   CPU_WIDTH = 32,
   parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
   parameter logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 imem_req_valid,
   input  logic                 imem_req_ready,
   output logic [CPU_WIDTH-1:0] imem_addr,
   input  logic                 imem_rsp_valid,
   input  logic [CPU_WIDTH-1:0] imem_rsp_data,
   input  logic                 imem_rsp_err,
   output logic [CPU_WIDTH-1:0] inst,
   output logic [CPU_WIDTH-1:0] inst_pc,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   output logic                 inst_fault,
   input  logic [CPU_WIDTH-1:0] next_pc,
   input  logic                 flush,
   input  logic [CPU_WIDTH-1:0] flush_pc
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } state_e;

   state_e               state_q,      state_d;
   logic [CPU_WIDTH-1:0] pc_q,         pc_d;
   logic [CPU_WIDTH-1:0] inst_q,       inst_d;
   logic [CPU_WIDTH-1:0] inst_pc_q,    inst_pc_d;
   logic                 inst_valid_q, inst_valid_d;
   logic                 inst_fault_q, inst_fault_d;
   logic                 drop_q,       drop_d;

   logic misaligned;
   logic req_fire;
   logic inst_fire;

   // The request is decoded from state and pc only, so no input can reach
   // imem_req_valid or imem_addr combinationally.
   assign misaligned     = |pc_q[1:0];
   assign imem_req_valid = (state_q == ST_REQ) && !misaligned;
   assign imem_addr      = pc_q;

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign inst_fire = inst_valid_q && inst_ready;

   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = inst_valid_q;
   assign inst_fault = inst_fault_q;

   always_comb begin
      // NOTE: every *_d defaults to its current value first, so any path that
      // does not assign it simply holds state and no latch is inferred.
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      inst_valid_d = inst_valid_q;
      inst_fault_d = inst_fault_q;
      drop_d       = drop_q;

      unique case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (flush) pc_d = flush_pc;
         end

         ST_REQ: begin
            if (flush) begin
               pc_d = flush_pc;
               // A request that leaves this cycle is already committed to
               // memory; its response must be thrown away in WAIT.
               if (req_fire) begin
                  drop_d  = 1'b1;
                  state_d = ST_WAIT;
               end
            end else if (misaligned) begin
               // Misaligned PC never reaches memory; deliver a faulting NOP.
               inst_d       = NOP_INST;
               inst_pc_d    = pc_q;
               inst_fault_d = 1'b1;
               inst_valid_d = 1'b1;
               state_d      = ST_HOLD;
            end else if (req_fire) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            if (imem_rsp_valid) begin
               if (drop_q || flush) begin
                  // Stale response (or one cancelled by a flush arriving with
                  // it): discard and refetch from the current/redirected pc.
                  // Going straight to REQ here avoids waiting for a response
                  // that will never come.
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
                  if (flush) pc_d = flush_pc;
               end else begin
                  inst_d       = imem_rsp_err ? NOP_INST : imem_rsp_data;
                  inst_pc_d    = pc_q;
                  inst_fault_d = imem_rsp_err;
                  inst_valid_d = 1'b1;
                  state_d      = ST_HOLD;
               end
            end else if (flush) begin
               pc_d   = flush_pc;
               drop_d = 1'b1;
            end
         end

         ST_HOLD: begin
            if (flush) begin
               // Redirect wins over a simultaneous handshake; next_pc ignored.
               inst_valid_d = 1'b0;
               pc_d         = flush_pc;
               state_d      = ST_REQ;
            end else if (inst_fire) begin
               inst_valid_d = 1'b0;
               pc_d         = next_pc;
               state_d      = ST_REQ;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state is written only with non-blocking assignments so
   // every flop samples the pre-edge values computed above.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= NOP_INST;
         inst_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         inst_fault_q <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         inst_valid_q <= inst_valid_d;
         inst_fault_q <= inst_fault_d;
         drop_q       <= drop_d;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch -- self-checking bench for ifu_fetch
//
// A memory model answers each accepted request after a configurable latency
// with data derived from the address. Directed scenarios walk through reset,
// first fetch, decoder stall, request backpressure, flush in WAIT, faults,
// misaligned PC and reset mid-fetch; a randomized phase then tracks the
// program counter the decoder should see and checks every presented
// instruction against it.
// ---------------------------------------------------------------------------
module tb_ifu_fetch;

   localparam int          W        = 32;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req_valid;
   logic          imem_req_ready;
   logic [W-1:0]  imem_addr;
   logic          imem_rsp_valid;
   logic [W-1:0]  imem_rsp_data;
   logic          imem_rsp_err;
   logic [W-1:0]  inst;
   logic [W-1:0]  inst_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic          inst_fault;
   logic [W-1:0]  next_pc;
   logic          flush;
   logic [W-1:0]  flush_pc;

   ifu_fetch #(
      .CPU_WIDTH(W),
      .RESET_PC (RESET_PC),
      .NOP_INST (NOP_INST)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_addr     (imem_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .imem_rsp_err  (imem_rsp_err),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .inst_fault    (inst_fault),
      .next_pc       (next_pc),
      .flush         (flush),
      .flush_pc      (flush_pc)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Memory model state: at most one response in flight.
   bit          mem_pend      = 1'b0;
   int          mem_cnt       = 0;
   logic [31:0] mem_pend_addr = '0;
   int          mem_lat       = 1;
   int          mem_accepts   = 0;

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      if (a == RESET_PC)      return 32'h0010_0093;
      if (a == 32'h8000_0004) return 32'hDEAD_BEEF;
      return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'h0F0F};
   endfunction

   // Addresses whose low byte index is 0x2B (e.g. ...AC) raise an access fault.
   function automatic logic mem_err(input logic [31:0] a);
      return a[7:2] == 6'h2B;
   endfunction

   typedef struct packed {
      logic        req_valid;
      logic [31:0] addr;
      logic        inst_valid;
      logic [31:0] inst;
      logic [31:0] inst_pc;
      logic        fault;
   } view_t;

   // Fields that carry no meaning while their valid is low are zeroed.
   function automatic view_t norm(input view_t v);
      view_t r = v;
      if (!r.req_valid) r.addr = '0;
      if (!r.inst_valid) begin
         r.inst    = '0;
         r.inst_pc = '0;
         r.fault   = 1'b0;
      end
      return r;
   endfunction

   function automatic view_t observe();
      view_t v;
      v.req_valid  = imem_req_valid;
      v.addr       = imem_addr;
      v.inst_valid = inst_valid;
      v.inst       = inst;
      v.inst_pc    = inst_pc;
      v.fault      = inst_fault;
      return norm(v);
   endfunction

   function automatic view_t mk(input logic rv, input logic [31:0] a, input logic iv,
                                input logic [31:0] i, input logic [31:0] p, input logic f);
      view_t v;
      v.req_valid  = rv;
      v.addr       = a;
      v.inst_valid = iv;
      v.inst       = i;
      v.inst_pc    = p;
      v.fault      = f;
      return norm(v);
   endfunction

   function automatic string fmt(input view_t v);
      return $sformatf("req=%0b addr=%h iv=%0b inst=%h pc=%h fault=%0b",
                       v.req_valid, v.addr, v.inst_valid, v.inst, v.inst_pc, v.fault);
   endfunction

   // Advance one clock. Called just after a falling edge; drives the memory
   // response for this cycle, records an accepted request, then returns after
   // the next falling edge so outputs are sampled away from the rising edge.
   task automatic step();
      if (mem_pend && mem_cnt == 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_data(mem_pend_addr);
         imem_rsp_err   = mem_err(mem_pend_addr);
         mem_pend       = 1'b0;
      end else begin
         if (mem_pend) mem_cnt--;
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = $urandom;
         imem_rsp_err   = 1'($urandom_range(0, 1));
      end
      if (!rst && imem_req_valid && imem_req_ready) begin
         vectors++;
         if (mem_pend) begin
            miscompares++;
            $display("FAIL outstanding: got second request to %h, required none while %h pending",
                     imem_addr, mem_pend_addr);
         end
         mem_pend      = 1'b1;
         mem_cnt       = mem_lat - 1;
         mem_pend_addr = imem_addr;
         mem_accepts++;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [66:0] got;
      logic [66:0] want;
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b0;
      next_pc        = '0;
      flush          = 1'b0;
      flush_pc       = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      repeat (3) step();
      got  = {imem_req_valid, inst_valid, inst_fault, inst, inst_pc};
      want = {1'b0, 1'b0, 1'b0, NOP_INST, 32'h0};
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL reset_values: got %h, required %h", got, want);
      end
   endtask

   task automatic test_first_fetch();
      view_t obs, exp;
      rst            = 1'b0;
      mem_lat        = 1;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b0;
      obs = observe(); exp = mk(0, 0, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL first_idle: got %s, required %s", fmt(obs), fmt(exp));
      end
      step();
      obs = observe(); exp = mk(1, RESET_PC, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL first_req: got %s, required %s", fmt(obs), fmt(exp));
      end
      step();
      obs = observe(); exp = mk(0, 0, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL first_wait: got %s, required %s", fmt(obs), fmt(exp));
      end
      step();
      obs = observe(); exp = mk(0, 0, 1, 32'h0010_0093, RESET_PC, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL first_inst: got %s, required %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_stall();
      view_t obs, exp;
      inst_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         next_pc = $urandom;
         step();
         obs = observe(); exp = mk(0, 0, 1, 32'h0010_0093, RESET_PC, 0); vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
         end
      end
      next_pc    = 32'h8000_0004;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      obs = observe(); exp = mk(1, 32'h8000_0004, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL stall_release: got %s, required %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_req_backpressure();
      view_t obs, exp;
      int    acc;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         obs = observe(); exp = mk(1, 32'h8000_0004, 0, 0, 0, 0); vectors++;
         if (obs !== exp) begin
            miscompares++;
            $display("FAIL backpressure_hold[%0d]: got %s, required %s", i, fmt(obs), fmt(exp));
         end
      end
      acc            = mem_accepts;
      mem_lat        = 2;
      imem_req_ready = 1'b1;
      step();
      obs = observe(); exp = mk(0, 0, 0, 0, 0, 0); vectors++;
      if (obs !== exp || mem_accepts != acc + 1) begin
         miscompares++;
         $display("FAIL backpressure_accept: got %s accepts=%0d, required %s accepts=%0d",
                  fmt(obs), mem_accepts - acc, fmt(exp), 1);
      end
   endtask

   task automatic test_flush_wait();
      view_t obs, exp;
      flush    = 1'b1;
      flush_pc = 32'h8000_0100;
      step();
      flush    = 1'b0;
      flush_pc = $urandom;
      obs = observe(); exp = mk(0, 0, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL flush_wait: got %s, required %s", fmt(obs), fmt(exp));
      end
      mem_lat = 1;
      step();  // stale 32'hDEAD_BEEF response arrives here
      obs = observe(); exp = mk(1, 32'h8000_0100, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL flush_drop: got %s, required %s", fmt(obs), fmt(exp));
      end
      step();
      step();
      obs = observe(); exp = mk(0, 0, 1, mem_data(32'h8000_0100), 32'h8000_0100, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL flush_refetch: got %s, required %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_fault();
      view_t obs, exp;
      int    acc;
      next_pc    = 32'h8000_00AC;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      obs = observe(); exp = mk(1, 32'h8000_00AC, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL fault_req: got %s, required %s", fmt(obs), fmt(exp));
      end
      step();
      step();
      obs = observe(); exp = mk(0, 0, 1, NOP_INST, 32'h8000_00AC, 1); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL fault_rsp: got %s, required %s", fmt(obs), fmt(exp));
      end
      next_pc    = 32'h8000_0002;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      acc        = mem_accepts;
      obs = observe(); exp = mk(0, 0, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL misalign_noreq: got %s, required %s", fmt(obs), fmt(exp));
      end
      step();
      obs = observe(); exp = mk(0, 0, 1, NOP_INST, 32'h8000_0002, 1); vectors++;
      if (obs !== exp || mem_accepts != acc) begin
         miscompares++;
         $display("FAIL misalign_inst: got %s accepts=%0d, required %s accepts=0",
                  fmt(obs), mem_accepts - acc, fmt(exp));
      end
      next_pc    = 32'h8000_0008;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      obs = observe(); exp = mk(1, 32'h8000_0008, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL misalign_next: got %s, required %s", fmt(obs), fmt(exp));
      end
   endtask

   task automatic test_reset_mid_fetch();
      view_t       obs, exp;
      logic [66:0] got;
      logic [66:0] want;
      mem_lat = 2;
      step();           // request to 0x8000_0008 accepted
      rst = 1'b1;
      step();           // reset taken while in WAIT
      step();           // the stale response arrives during reset
      got  = {imem_req_valid, inst_valid, inst_fault, inst, inst_pc};
      want = {1'b0, 1'b0, 1'b0, NOP_INST, 32'h0};
      vectors++;
      if (got !== want) begin
         miscompares++; $display("FAIL reset_mid_values: got %h, required %h", got, want);
      end
      rst      = 1'b0;
      mem_pend = 1'b0;
      step();
      obs = observe(); exp = mk(1, RESET_PC, 0, 0, 0, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL reset_mid_req: got %s, required %s", fmt(obs), fmt(exp));
      end
      mem_lat = 1;
      step();
      step();
      obs = observe(); exp = mk(0, 0, 1, 32'h0010_0093, RESET_PC, 0); vectors++;
      if (obs !== exp) begin
         miscompares++; $display("FAIL reset_mid_inst: got %s, required %s", fmt(obs), fmt(exp));
      end
   endtask

   function automatic logic [31:0] pick_pc(input logic [31:0] p);
      int r = $urandom_range(0, 15);
      logic [31:0] x = $urandom;
      if (r < 8)   return p + 32'd4;
      if (r < 13)  return {16'h8000, x[15:2], 2'b00};
      if (r == 13) return {p[31:8], 8'hAC};
      return {16'h8000, x[15:2], 2'b10};
   endfunction

   // Model: the decoder must see exactly the instruction at exp_pc, which
   // moves to next_pc on a consumed instruction and to flush_pc on a flush.
   task automatic test_random();
      logic [31:0] exp_pc     = RESET_PC;
      logic [31:0] exp_inst;
      logic        exp_fault;
      bit          prev_hold  = 1'b0;
      bit          fire;
      int          idle       = 0;
      int          handshakes = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (imem_req_valid) begin
            vectors++;
            if (imem_addr !== exp_pc || exp_pc[1:0] != 2'b00) begin
               miscompares++;
               $display("FAIL rand_addr cyc %0d: got %h, required aligned %h", cyc, imem_addr, exp_pc);
            end
         end
         if (inst_valid) begin
            exp_fault = (exp_pc[1:0] != 2'b00) || mem_err(exp_pc);
            exp_inst  = exp_fault ? NOP_INST : mem_data(exp_pc);
            vectors++;
            if ({inst, inst_pc, inst_fault} !== {exp_inst, exp_pc, exp_fault}) begin
               miscompares++;
               $display("FAIL rand_inst cyc %0d: got %h/%h/%0b, required %h/%h/%0b", cyc,
                        inst, inst_pc, inst_fault, exp_inst, exp_pc, exp_fault);
            end
         end
         if (prev_hold) begin
            vectors++;
            if (inst_valid !== 1'b1) begin
               miscompares++;
               $display("FAIL rand_hold cyc %0d: got inst_valid=%b, required 1", cyc, inst_valid);
            end
         end
         imem_req_ready = ($urandom_range(0, 2) != 0);
         mem_lat        = $urandom_range(1, 4);
         inst_ready     = 1'($urandom_range(0, 1));
         flush          = ($urandom_range(0, 19) == 0);
         flush_pc       = pick_pc(exp_pc);
         next_pc        = pick_pc(exp_pc);
         fire           = inst_valid && inst_ready;
         prev_hold      = inst_valid && !inst_ready && !flush;
         if (flush) exp_pc = flush_pc;
         else if (fire) exp_pc = next_pc;
         if (fire && !flush) begin
            handshakes++;
            idle = 0;
         end else begin
            idle++;
         end
         if (idle > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL rand_liveness cyc %0d: got no handshake for %0d cycles, required fewer than 200",
                     cyc, idle);
            break;
         end
         step();
      end
      flush      = 1'b0;
      inst_ready = 1'b0;
      vectors++;
      if (handshakes < 100) begin
         miscompares++;
         $display("FAIL rand_throughput: got %0d handshakes, required at least 100", handshakes);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_first_fetch();
      test_stall();
      test_req_backpressure();
      test_flush_wait();
      test_fault();
      test_reset_mid_fetch();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
